// File: rtl/pdp8_io_pkg.sv
// Shared PDP-8 positive-I/O-bus definitions: IOP pulse bits, device codes and
// the serial frame state type used by the character shifters.
package pdp8_io_pkg;

    typedef enum logic [2:0] {
        IOP1 = 3'd1,
        IOP2 = 3'd2,
        IOP4 = 3'd4
    } iop_bit_t;

    localparam logic [5:0] DEV_KL8_KBD = 6'o03;
    localparam logic [5:0] DEV_KL8_TTY = 6'o04;
    localparam logic [5:0] DEV_PUNCH   = 6'o02;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/serial_tx_shifter.sv
// Asynchronous character transmitter: one start bit, 8 data bits LSB first,
// STOP_BITS stop bits, each bit CLK_DIV clocks long.
//
//   state | meaning
//   IDLE  | line high, waiting for load
//   START | start bit (line low)
//   DATA  | data bits, buf_q[bit_q] on the line
//   STOP  | stop bit(s), line high; done_pulse on the last cycle
module serial_tx_shifter
    import pdp8_io_pkg::*;
#(
    parameter logic [15:0] CLK_DIV   = 16'd1302,
    parameter int          STOP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_byte,
    output logic       tx,
    output logic       busy,
    output logic       done_pulse
);

    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [15:0] BAUD_LAST = CLK_DIV - 16'd1;

    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic        stop_q, stop_d;
    logic [7:0]  buf_q, buf_d;
    logic        baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        buf_d      = buf_q;
        tx         = 1'b1;
        busy       = 1'b1;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                busy   = 1'b0;
                baud_d = '0;
                if (load) begin
                    buf_d   = data_byte;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                tx = buf_q[bit_q];
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        done_pulse = 1'b1;
                        stop_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/iot_serial_punch.sv
// Punch/printer style IOT device: decodes its device code, handles IOP1 skip,
// IOP2 flag clear and IOP4 load-and-go, and drives a serial TX line.
module iot_serial_punch
    import pdp8_io_pkg::*;
#(
    parameter logic [5:0]  DEV_CODE  = DEV_PUNCH,
    parameter logic [15:0] CLK_DIV   = 16'd1302,
    parameter int          STOP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_o_pwr_clr,
    input  logic        iop_1,
    input  logic        iop_2,
    input  logic        iop_4,
    input  logic [11:0] io_bmb,
    input  logic [11:0] io_bac,
    output logic        i_o_skp_rq_l,
    output logic        i_o_int_rq_l,
    output logic        tx_data,
    output logic        busy
);

    logic       clr;
    logic       sel;
    logic [2:0] iop_v, iop_q, act;
    logic       act_1, act_2, act_4;
    logic       flag, skp_rq_l_q, int_rq_l_q;
    logic       done_pulse;
    logic       unused_bus_bits;

    assign clr   = rst | i_o_pwr_clr;
    assign sel   = (io_bmb[8:3] == DEV_CODE);
    assign iop_v = {iop_4, iop_2, iop_1};
    // One action per pulse: only the first cycle of a selected IOP counts.
    assign act   = iop_v & ~iop_q & {3{sel}};
    assign act_1 = |(act & IOP1);
    assign act_2 = |(act & IOP2);
    assign act_4 = |(act & IOP4);

    assign unused_bus_bits = ^{io_bmb[11:9], io_bmb[2:0], io_bac[11:8]};

    always_ff @(posedge clk) begin
        if (clr) begin
            iop_q      <= '0;
            flag       <= 1'b0;
            skp_rq_l_q <= 1'b1;
            int_rq_l_q <= 1'b1;
        end else begin
            iop_q <= iop_v;
            // A completing character beats a simultaneous clear.
            if (done_pulse) begin
                flag <= 1'b1;
            end else if (act_2) begin
                flag <= 1'b0;
            end
            int_rq_l_q <= ~flag;
            // Skip latches on a selected IOP1 edge with flag set and holds for the pulse.
            skp_rq_l_q <= ~(iop_1 & ((act_1 & flag) | ~skp_rq_l_q));
        end
    end

    assign i_o_skp_rq_l = skp_rq_l_q;
    assign i_o_int_rq_l = int_rq_l_q;

    serial_tx_shifter #(
        .CLK_DIV   (CLK_DIV),
        .STOP_BITS (STOP_BITS)
    ) u_shifter (
        .clk        (clk),
        .rst        (clr),
        .load       (act_4),
        .data_byte  (io_bac[7:0]),
        .tx         (tx_data),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

endmodule

// File: doc/iot_serial_punch.md
Name: iot_serial_punch

Overview:
- Positive-I/O-bus peripheral: the device end of the processor's IOT interface.
- Decodes its device code from the IO buffered MB and responds to IOP1/IOP2/IOP4 pulses with a skip request, an interrupt request and a flag.
- Serialises AC[4:11] as an 8-bit asynchronous character on a TX line, like a punch or printer channel.
- Sits beside the CPU core in the top-level wrapper, replacing the tied-off skip/interrupt request lines.

Parameters:
- DEV_CODE, 6'o02, device select code compared against io_bmb[3:8].
- CLK_DIV, 16'd1302, clk cycles per serial bit; legal range is 2..65535.
- STOP_BITS, 2, number of stop bits; legal values are 1 and 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_o_pwr_clr  in  1  bus power clear, active-high; same effect as rst
- iop_1  in  1  IOP1 pulse, active-high, one or more cycles long
- iop_2  in  1  IOP2 pulse, active-high
- iop_4  in  1  IOP4 pulse, active-high
- io_bmb  in  12  buffered MB; bits [3:8] in PDP numbering carry the device code
- io_bac  in  12  buffered AC; bits [4:11] carry the data byte
- i_o_skp_rq_l  out  1  skip request, active-low
- i_o_int_rq_l  out  1  interrupt request, active-low
- tx_data  out  1  serial output; idles high
- busy  out  1  shifter active (status only)

Behaviour:
- Bit numbering is PDP style: bit 0 is the MSB. io_bmb[3:8] is vector bits [8:3]. The data byte is io_bac[7:0], with bit 11 as the LSB.
- sel = (io_bmb[8:3] == DEV_CODE), evaluated combinationally.
- Each IOP input passes through a one-flop edge detector. An action fires in the cycle after the rising edge, and only if sel is true in the edge cycle. A long pulse therefore acts exactly once.
- Reset (rst or i_o_pwr_clr):
  - flag = 0, state IDLE, bit counter = 0, baud counter = 0, edge flops = 0.
  - tx_data = 1, busy = 0, i_o_skp_rq_l = 1, i_o_int_rq_l = 1.
  - Reset mid-character aborts the frame; tx_data returns high on the next cycle.
- IOP1 (skip on flag): i_o_skp_rq_l is registered.
  - It goes low starting 1 cycle after the IOP1 rising edge if sel and flag = 1.
  - It stays low while iop_1 remains high and goes high 1 cycle after iop_1 falls.
  - It is never low outside an IOP1 pulse.
- IOP2 (clear flag): flag <= 0.
- IOP4 (load and go):
  - If state == IDLE, latch io_bac[7:0] into the shift buffer and enter START.
  - If busy, the IOP4 is ignored: the buffer and frame in progress are unchanged.
- IOP2 and IOP4 in the same instruction (6xx6, TLS) are both honoured: the flag clears and the character starts.
- Serial frame FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_data = 1, busy = 0.
  - START: tx_data = 0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB (AC bit 11) first, each CLK_DIV cycles. The bit counter runs 0..7 and wraps to 0 on exit.
  - STOP: tx_data = 1 for STOP_BITS*CLK_DIV cycles.
  - busy = 1 in START, DATA and STOP.
- Baud counter: counts 0..CLK_DIV-1, reloads to 0 on every state or bit boundary, and holds at 0 in IDLE.
- Completion: on the final cycle of STOP, flag <= 1 and state <= IDLE. The first start bit appears on tx_data 1 cycle after the IOP4 action cycle.
- If flag-set and an IOP2 clear land in the same cycle, set wins.
- i_o_int_rq_l = ~flag, registered; it follows flag with 1 cycle delay.
- The IDLE -> START transition can coincide with the flag-set of the previous frame only via IOP4. No back-to-back gap is required beyond 1 idle cycle.

Decomposition:
- Shared package pdp8_io_pkg holds:
  - the IOP bit enum (IOP1 = 1, IOP2 = 2, IOP4 = 4);
  - device code constants (KL8 = 6'o03/6'o04, PUNCH = 6'o02);
  - the tx_state_t typedef (IDLE, START, DATA, STOP).
- One natural sub-module, serial_tx_shifter, contains the baud counter, bit counter and frame FSM.
  - Its inputs are load and byte; its outputs are tx, busy and done_pulse.
- The top level keeps the IOP edge detect, device decode, flag and skip/int logic.

Test Plan:
- CLK_DIV=4, STOP_BITS=2, io_bmb=12'o6024, io_bac=12'o0101, 3-cycle iop_4 pulse:
  - tx_data low for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 8 cycles.
  - flag/int_rq_l goes low 1 cycle after STOP ends.
  - Exactly one frame is sent.
- Flag set, io_bmb=12'o6021, iop_1 held 5 cycles:
  - i_o_skp_rq_l low from cycle 2 through 1 cycle after iop_1 falls.
  - Repeat with io_bmb=12'o6031 (wrong device): i_o_skp_rq_l stays 1.
- Flag set, 6xx6 with iop_2 then iop_4:
  - i_o_int_rq_l returns 1 two cycles after the iop_2 edge, and a new frame starts.
- iop_4 with io_bac=12'o0377 issued mid-frame:
  - The frame in progress is unchanged, and no second frame follows.
- rst asserted during DATA bit 3:
  - The next cycle has tx_data=1, busy=0 and flag=0.
  - A subsequent iop_4 transmits normally.
- Flag-set cycle coincides with an iop_2 action:
  - flag ends at 1 and i_o_int_rq_l=0.
